// File: rtl/vbb_video_timing_gen.sv
// Raster timing generator: free-running h/v counters with fully registered
// sync, blank, active-video and start-pulse decodes, all aligned to pix_x/pix_y.
module vbb_video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 12
) (
  input  logic             clk,
  input  logic             ext_reset,
  input  logic             ce,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank,
  output logic             vblank,
  output logic             active_video,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  int               h_next_i;
  int               v_next_i;
  logic             hsync_next;
  logic             vsync_next;
  logic             hblank_next;
  logic             vblank_next;

  // Next position; decodes are taken from it so every registered output
  // describes the same position as pix_x/pix_y after the edge.
  always_comb begin
    h_wrap = (int'(pix_x) == H_TOTAL - 1);
    v_wrap = (int'(pix_y) == V_TOTAL - 1);
    h_next = h_wrap ? '0 : pix_x + CNT_W'(1);
    v_next = pix_y;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : pix_y + CNT_W'(1);
    end
    h_next_i    = int'(h_next);
    v_next_i    = int'(v_next);
    hblank_next = (h_next_i >= H_ACTIVE);
    vblank_next = (v_next_i >= V_ACTIVE);
    hsync_next  = ((h_next_i >= HS_START) && (h_next_i < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_next  = ((v_next_i >= VS_START) && (v_next_i < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (ext_reset) begin
      // Park at the start of vertical front porch so vblank is high throughout reset.
      pix_x        <= '0;
      pix_y        <= CNT_W'(V_ACTIVE);
      hblank       <= 1'b0;
      vblank       <= 1'b1;
      active_video <= 1'b0;
      hsync        <= ~HSYNC_POL;
      vsync        <= ~VSYNC_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else if (ce) begin
      pix_x        <= h_next;
      pix_y        <= v_next;
      hblank       <= hblank_next;
      vblank       <= vblank_next;
      active_video <= ~hblank_next & ~vblank_next;
      hsync        <= hsync_next;
      vsync        <= vsync_next;
      line_start   <= (h_next == '0);
      frame_start  <= (h_next == '0) && (v_next == '0);
    end else begin
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vbb_video_timing_gen.sv
// Scoreboard bench for vbb_video_timing_gen on an 8x6 raster; a linear
// frame-position model predicts every output, a monitor compares each cycle.
module tb_vbb_video_timing_gen;

  localparam int HT = 8;
  localparam int VT = 6;
  localparam int FT = HT * VT;
  localparam int VA = 3;
  localparam int W  = 12;

  logic         clk = 1'b0;
  logic         ext_reset;
  logic         ce;
  logic [W-1:0] pix_x, pix_y, pix_x_n, pix_y_n;
  logic         hsync, vsync, hblank, vblank, active_video, line_start, frame_start;
  logic         hsync_n, vsync_n, hblank_n, vblank_n, active_video_n, line_start_n, frame_start_n;

  vbb_video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(W)
  ) dut (
    .clk(clk), .ext_reset(ext_reset), .ce(ce),
    .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .active_video(active_video),
    .line_start(line_start), .frame_start(frame_start)
  );

  vbb_video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(W)
  ) dut_n (
    .clk(clk), .ext_reset(ext_reset), .ce(ce),
    .pix_x(pix_x_n), .pix_y(pix_y_n), .hsync(hsync_n), .vsync(vsync_n),
    .hblank(hblank_n), .vblank(vblank_n), .active_video(active_video_n),
    .line_start(line_start_n), .frame_start(frame_start_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y;
    bit hs; bit vs; bit hb; bit vb; bit av; bit ls; bit fs;
  } exp_t;

  exp_t q[$];
  int   p;
  int   tests = 0;
  int   fails = 0;
  int   txn   = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s txn=%0d actual=%0d expected=%0d", name, txn, act, exp);
    end
  endtask

  // Model: position is a linear index into the frame; everything else is arithmetic on it.
  task automatic step(input bit rst, input bit c);
    exp_t e;
    @(negedge clk);
    ext_reset = rst;
    ce        = c;
    e.ls = 1'b0;
    e.fs = 1'b0;
    if (rst) begin
      p = VA * HT;
    end else if (c) begin
      p    = (p + 1) % FT;
      e.ls = (p % HT == 0);
      e.fs = (p == 0);
    end
    e.x  = p % HT;
    e.y  = p / HT;
    e.hb = (e.x >= 4);
    e.vb = (e.y >= VA);
    e.av = !e.hb && !e.vb;
    e.hs = (e.x == 5) || (e.x == 6);
    e.vs = (e.y == 4);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    int   f0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        txn++;
        f0 = fails;
        check("pix_x", int'(pix_x), e.x);
        check("pix_y", int'(pix_y), e.y);
        check("hsync", int'(hsync), int'(e.hs));
        check("vsync", int'(vsync), int'(e.vs));
        check("hblank", int'(hblank), int'(e.hb));
        check("vblank", int'(vblank), int'(e.vb));
        check("active_video", int'(active_video), int'(e.av));
        check("line_start", int'(line_start), int'(e.ls));
        check("frame_start", int'(frame_start), int'(e.fs));
        check("hsync_lowpol", int'(hsync_n), int'(!e.hs));
        check("vsync_lowpol", int'(vsync_n), int'(!e.vs));
        $display("[TB] txn %0d rst=%0d ce=%0d pos=(%0d,%0d) hs=%0d vs=%0d ls=%0d fs=%0d %s",
                 txn, ext_reset, ce, pix_x, pix_y, hsync, vsync, line_start, frame_start,
                 (fails == f0) ? "ok" : "bad");
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic wait_frame_start(input string name, input int exp_cycles);
    int n;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      step(1'b0, 1'b1);
      @(posedge clk);
      #1;
      if (frame_start) begin
        n = i;
        break;
      end
    end
    check(name, n, exp_cycles);
  endtask

  initial begin : driver
    int av_cnt, ls_cnt, guard;
    ext_reset = 1'b1;
    ce        = 1'b1;
    p         = VA * HT;
    repeat (5) step(1'b1, 1'b1);

    wait_frame_start("first_frame_start", 24);
    wait_frame_start("frame_period", 48);

    av_cnt = 0;
    ls_cnt = 0;
    for (int i = 0; i < FT; i++) begin
      step(1'b0, 1'b1);
      @(posedge clk);
      #1;
      if (active_video) av_cnt++;
      if (line_start) ls_cnt++;
    end
    check("active_per_frame", av_cnt, 12);
    check("lines_per_frame", ls_cnt, VT);

    for (int i = 0; i < 120; i++) step(1'b0, (i % 2) == 0);

    guard = 0;
    while (p != (1 * HT + 2) && guard < 100) begin
      step(1'b0, 1'b1);
      guard++;
    end
    check("reach_mid_frame", p, 1 * HT + 2);
    step(1'b1, 1'b1);
    wait_frame_start("frame_after_midreset", 24);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 64) == 0, ($urandom % 4) != 0);
    end
    repeat (3) step(1'b0, 1'b1);

    @(posedge clk);
    #2;
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vbb_video_timing_gen.md
# vbb_video_timing_gen

Raster timing generator for the vision flow pipeline. It produces hsync, vsync, hblank, vblank, active-video and pixel coordinates from free-running horizontal and vertical counters. Its `vblank` output drives the system reset generator's release condition, and it feeds the downstream frame-synchronous stages. Because it sources `vblank` for system reset release, it runs from the external reset and never from `system_reset`.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: active lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `HSYNC_POL`, 0: asserted level of hsync (1 = active-high)
- `VSYNC_POL`, 0: asserted level of vsync
- `CNT_W`, 12: counter and coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W

Ports:
- `clk` in 1: single system clock
- `ext_reset` in 1: synchronous, active-high reset
- `ce` in 1: pixel clock enable; counters advance only on cycles where `ce`=1
- `pix_x` out CNT_W: horizontal counter `h_cnt`, range 0..H_TOTAL-1
- `pix_y` out CNT_W: vertical counter `v_cnt`, range 0..V_TOTAL-1
- `hsync` out 1: horizontal sync, polarity set by HSYNC_POL
- `vsync` out 1: vertical sync, polarity set by VSYNC_POL
- `hblank` out 1: high when h_cnt ≥ H_ACTIVE
- `vblank` out 1: high when v_cnt ≥ V_ACTIVE
- `active_video` out 1: ~hblank & ~vblank
- `line_start` out 1: one-cycle pulse when the counters land on h_cnt=0
- `frame_start` out 1: one-cycle pulse when the counters land on (0,0)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Every output is a register. All outputs describe the same (h_cnt, v_cnt) position in the same cycle; there is no skew between them.
- On a `ce`=1 cycle:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At V_TOTAL-1, v_cnt wraps to 0, in the same cycle h_cnt wraps.
- On a `ce`=0 cycle, counters and level outputs hold.
- hsync is asserted for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines (it switches on the h_cnt wrap).
- `line_start` is 1 for exactly the clk cycle following a ce-advance that lands on h_cnt=0. It is 0 on every other cycle, including held `ce`=0 cycles.
- `frame_start` follows the same rule for landing on (0,0). `line_start` is also 1 in that cycle.
- Counter arithmetic is unsigned, CNT_W bits, with explicit compare-and-wrap. Counters never pass through values ≥ the total.

## Timing
- Reset state, applied while `ext_reset`=1, regardless of `ce`:
  - h_cnt=0, v_cnt=V_ACTIVE (start of vertical front porch)
  - hblank=0, vblank=1, active_video=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - line_start=0, frame_start=0
- Because `vblank`=1 throughout reset, the system reset generator can release at its first evaluation.
- Reset asserted mid-frame returns the block to the reset state on the next clk edge. No partial pulse is emitted.
- Latency: a ce-advance at edge n shows the new position and all decodes after edge n; there is no additional pipeline stage.
- With `ce` tied to 1:
  - first `frame_start` comes (V_TOTAL-V_ACTIVE)·H_TOTAL cycles after reset deasserts
  - `frame_start` then repeats every H_TOTAL·V_TOTAL cycles
  - `line_start` repeats every H_TOTAL cycles

## Test plan
Small configuration for all scenarios: H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), HSYNC_POL=1, VSYNC_POL=1, unless stated otherwise.
- **Reset values:** hold `ext_reset`=1 for 5 cycles with `ce`=1 → pix_x=0, pix_y=3, vblank=1, hblank=0, hsync=0, vsync=0, frame_start=0 every cycle.
- **Frame cadence:** release reset, `ce`=1 → first frame_start on cycle 24 at (0,0); next on cycle 72; line_start every 8 cycles; frame_start never at other positions.
- **Decode windows:**
  - hsync=1 exactly at pix_x 5,6
  - hblank=1 at pix_x 4..7
  - vsync=1 for all 8 cycles of pix_y=4
  - vblank=1 for pix_y 3..5
  - active_video = 12 cycles per frame
- **Clock enable:** `ce` alternating 1/0 → counters advance every other cycle; frame_start high for a single clk cycle; counters and levels frozen on `ce`=0 cycles.
- **Mid-frame reset:** assert `ext_reset` at (2,1) for one cycle → next cycle at (0,3) with the reset output values; next frame_start 24 ce-cycles after release.
- **Polarity and wrap:** HSYNC_POL=0, VSYNC_POL=0 → sync levels inverted relative to the default-configuration runs; at (7,5) with `ce`=1, the next state is (0,0) with frame_start=1.
